// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_filter.sv
// Synchroniser, glitch filter and falling-edge strobe for the device-driven PS/2 clock.
module ps2_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            fall_q, fall_d;

  // cnt_q counts consecutive synchronised samples that disagree with the filtered level
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    fall_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        level_d = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Idle PS/2 lines are high, so reset to 1 to avoid a false edge after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: deserialises frames and folds E0/F0 prefixes into flags.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_ext,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic       clk_level;
  logic       fall;
  logic [1:0] data_sync_q;
  logic       data_s;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk_i  (clk),
    .rst_ni (rst),
    .raw_i  (ps2_clk),
    .level_o(clk_level),
    .fall_o (fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_sync_q <= 2'b11;
    else      data_sync_q <= {data_sync_q[0], ps2_data};
  end
  assign data_s = data_sync_q[1];

  ps2_state_e      state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      code_q, code_d;
  logic            is_break_q, is_break_d;
  logic            is_ext_q, is_ext_d;
  logic            code_valid_q, code_valid_d;
  logic            frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    tmo_d        = '0;
    code_d       = code_q;
    is_break_d   = is_break_q;
    is_ext_d     = is_ext_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!data_s) begin
            state_d  = StData;
            bitcnt_d = '0;
          end
        end
        StData: begin
          shift_d  = {data_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          parity_d = data_s;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (data_s && (^shift_q ^ parity_q)) begin
            if (shift_q == PS2_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
              brk_d = 1'b1;
            end else begin
              code_d       = shift_q;
              is_ext_d     = ext_q;
              is_break_d   = brk_q;
              code_valid_d = 1'b1;
              ext_d        = 1'b0;
              brk_d        = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      // A fall event in the same cycle takes priority over the abort
      if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
        frame_err_d = 1'b1;
        state_d     = StIdle;
        ext_d       = 1'b0;
        brk_d       = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      tmo_q        <= '0;
      code_q       <= '0;
      is_break_q   <= 1'b0;
      is_ext_q     <= 1'b0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      tmo_q        <= tmo_d;
      code_q       <= code_d;
      is_break_q   <= is_break_d;
      is_ext_q     <= is_ext_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign is_break   = is_break_q;
  assign is_ext     = is_ext_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != StIdle);

  logic unused_level;
  assign unused_level = clk_level;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: directed frames, expected events queued, monitor compares.
module tb_ps2_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] code;
  logic       code_valid;
  logic       is_break;
  logic       is_ext;
  logic       frame_err;
  logic       rx_busy;

  ps2_rx #(
    .FILTER_LEN (4),
    .TIMEOUT_CYC(200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code),
    .code_valid(code_valid),
    .is_break  (is_break),
    .is_ext    (is_ext),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_err_seen = 0;

  logic [7:0] held_code = 8'h00;
  logic       held_brk  = 1'b0;
  logic       held_ext  = 1'b0;

  task automatic chk(input string name, input bit ok, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_code(input logic [7:0] c, input logic brk, input logic ext);
    exp_t e;
    e.err = 1'b0; e.code = c; e.brk = brk; e.ext = ext;
    sb.push_back(e);
    held_code = c; held_brk = brk; held_ext = ext;
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1'b1; e.code = held_code; e.brk = held_brk; e.ext = held_ext;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per output pulse
  always @(negedge clk) begin
    if (code_valid || frame_err) begin
      exp_t e;
      if (frame_err) n_err_seen++;
      chk("no_overlap", !(code_valid && frame_err), {code_valid, frame_err}, 32'h0);
      chk("event_expected", sb.size() > 0, sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("event_kind", frame_err == e.err, frame_err, e.err);
        chk("code", code == e.code, code, e.code);
        chk("is_break", is_break == e.brk, is_break, e.brk);
        chk("is_ext", is_ext == e.ext, is_ext, e.ext);
      end
    end
  end

  // Odd parity: parity bit makes the XOR over data and parity equal 1
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (10) @(posedge clk);
      ps2_data = bits[i];
      repeat (10) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(posedge clk);
      ps2_clk = 1'b1;
    end
    repeat (20) @(posedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic settle(input string name);
    repeat (10) @(posedge clk);
    #1;
    chk(name, sb.size() == 0, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_seen;
    int err_before;
    rst      = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {code, code_valid, is_break, is_ext, frame_err, rx_busy} == 13'h0,
        {code, code_valid, is_break, is_ext, frame_err, rx_busy}, 0);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // 1: plain code
    push_code(8'h1D, 1'b0, 1'b0);
    send_bits(mk_frame(8'h1D, 0), 11);
    settle("t1_drain");

    // 2: break prefix
    send_bits(mk_frame(8'hF0, 0), 11);
    settle("t2_no_pulse_f0");
    push_code(8'h1D, 1'b1, 1'b0);
    send_bits(mk_frame(8'h1D, 0), 11);
    settle("t2_drain");

    // 3: extended break, then plain
    send_bits(mk_frame(8'hE0, 0), 11);
    send_bits(mk_frame(8'hF0, 0), 11);
    push_code(8'h75, 1'b1, 1'b1);
    send_bits(mk_frame(8'h75, 0), 11);
    settle("t3_ext_brk");
    push_code(8'h75, 1'b0, 1'b0);
    send_bits(mk_frame(8'h75, 0), 11);
    settle("t3_plain");

    // 4: parity error, then good frame
    push_err();
    send_bits(mk_frame(8'h1B, 1), 11);
    settle("t4_err");
    chk("t4_code_held", code == 8'h75, code, 8'h75);
    push_code(8'h1B, 1'b0, 1'b0);
    send_bits(mk_frame(8'h1B, 0), 11);
    settle("t4_good");

    // 5: timeout on partial frame (plain, then after F0)
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) send_bits(mk_frame(8'hF0, 0), 11);
      err_before = n_err_seen;
      push_err();
      for (int i = 0; i < 5; i++) begin
        repeat (10) @(posedge clk);
        ps2_data = (i == 0) ? 1'b0 : 1'b1;
        repeat (10) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (20) @(posedge clk);
        ps2_clk = 1'b1;
      end
      #1;
      chk("t5_busy_partial", rx_busy == 1'b1, rx_busy, 1);
      repeat (130) @(posedge clk);
      #1;
      chk("t5_no_early_err", n_err_seen == err_before, n_err_seen, err_before);
      repeat (120) @(posedge clk);
      #1;
      chk("t5_err_fired", n_err_seen == err_before + 1, n_err_seen, err_before + 1);
      chk("t5_busy_dropped", rx_busy == 1'b0, rx_busy, 0);
      push_code(8'h29, 1'b0, 1'b0);
      send_bits(mk_frame(8'h29, 0), 11);
      settle("t5_recover");
    end

    // 6: short glitch while idle
    busy_seen = 0;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rx_busy) busy_seen++;
    end
    chk("t6_glitch_ignored", busy_seen == 0, busy_seen, 0);

    // 6: reset mid-frame
    send_bits(mk_frame(8'h55, 0), 4);
    #1;
    chk("t6_busy_before_rst", rx_busy == 1'b1, rx_busy, 1);
    rst = 1'b0;
    #1;
    chk("t6_async_clear", {code, code_valid, is_break, is_ext, frame_err, rx_busy} == 13'h0,
        {code, code_valid, is_break, is_ext, frame_err, rx_busy}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_rst_outputs", {code, code_valid, is_break, is_ext, frame_err, rx_busy} == 13'h0,
        {code, code_valid, is_break, is_ext, frame_err, rx_busy}, 0);
    held_code = 8'h00; held_brk = 1'b0; held_ext = 1'b0;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    push_code(8'h1C, 1'b0, 1'b0);
    send_bits(mk_frame(8'h1C, 0), 11);
    settle("t6_recover");

    repeat (20) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
